// File: rtl/matrix_operand_fetch.sv
// rtl/matrix_operand_fetch.sv - operand fetch engine: metadata check, element reads, handshaked stream
// Optional column-major streaming of the last operand is enabled by defining OPERAND_COLMAJOR_EN.
module matrix_operand_fetch #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int NUM_OPS = 2,
  parameter int ID_W    = 4,
  parameter int SLOTS   = 10,
  parameter int TIMEOUT = 64,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              op_sel,
  input  logic [NUM_OPS*ID_W-1:0] id_in,
  input  logic                    col_major,
  output logic                    meta_req,
  output logic [ID_W-1:0]         meta_id,
  input  logic                    meta_valid,
  input  logic                    meta_present,
  input  logic [2:0]              meta_m,
  input  logic [2:0]              meta_n,
  output logic                    rd_req,
  output logic [ID_W-1:0]         rd_id,
  output logic [AW-1:0]           rd_addr,
  input  logic                    rd_valid,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [1:0]              out_op_idx,
  output logic [2:0]              out_row,
  output logic [2:0]              out_col,
  output logic                    out_last,
  output logic [NUM_OPS*6-1:0]    dims_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_MATMUL    = 3'b011;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_ID_DIM  = 3'b001;
  localparam logic [2:0] ERR_DIM_MIS = 3'b010;
  localparam logic [2:0] ERR_OP      = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_META_REQ,
    S_META_WAIT,
    S_CHECK,
    S_ELEM_REQ,
    S_ELEM_WAIT,
    S_ELEM_OUT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                op_q, op_d;
  logic [NUM_OPS*ID_W-1:0]   id_q, id_d;
  logic                      cm_q, cm_d;
  logic [1:0]                idx_q, idx_d;
  logic [2:0]                row_q, row_d;
  logic [2:0]                col_q, col_d;
  logic [TW-1:0]             wait_q, wait_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [NUM_OPS*6-1:0]      dims_q, dims_d;
  logic [2:0]                err_code_q, err_code_d;
  logic                      error_q, error_d;

  logic            two_op, op_bad, last_op, last_elem, cm_active, dims_ok, timed_out;
  logic [ID_W-1:0] cur_id;
  logic [2:0]      cur_m, cur_n, ma, na, mb, nb;
  logic [AW-1:0]   cur_addr;

  assign two_op    = (op_q == OP_ADD) || (op_q == OP_MATMUL);
  assign op_bad    = (op_q > OP_MATMUL) || (two_op && (NUM_OPS < 2));
  assign last_op   = two_op ? (idx_q == 2'd1) : (idx_q == 2'd0);
  assign cur_id    = id_q[int'(idx_q)*ID_W +: ID_W];
  assign cur_m     = dims_q[int'(idx_q)*6 + 3 +: 3];
  assign cur_n     = dims_q[int'(idx_q)*6 +: 3];
  assign last_elem = (row_q == cur_m - 3'd1) && (col_q == cur_n - 3'd1);
  assign cur_addr  = AW'(row_q) * AW'(cur_n) + AW'(col_q);
  assign timed_out = (wait_q == TW'(TIMEOUT - 1));
  assign dims_ok   = meta_present && (meta_m != 3'd0) && (meta_n != 3'd0) &&
                     (int'(meta_m) <= MAX_DIM) && (int'(meta_n) <= MAX_DIM);

  assign ma = dims_q[5:3];
  assign na = dims_q[2:0];
  generate
    if (NUM_OPS >= 2) begin : g_two_ops
      assign mb = dims_q[11:9];
      assign nb = dims_q[8:6];
    end else begin : g_one_op
      assign mb = 3'd0;
      assign nb = 3'd0;
    end
  endgenerate

`ifdef OPERAND_COLMAJOR_EN
  assign cm_active = cm_q && last_op;
`else
  logic unused_cm;
  assign unused_cm = cm_q;
  assign cm_active = 1'b0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign error    = error_q;
  assign err_code = err_code_q;
  assign dims_out = dims_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      id_q       <= '0;
      cm_q       <= 1'b0;
      idx_q      <= 2'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      wait_q     <= '0;
      data_q     <= '0;
      dims_q     <= '0;
      err_code_q <= ERR_NONE;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      cm_q       <= cm_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      dims_q     <= dims_d;
      err_code_q <= err_code_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    id_d       = id_q;
    cm_d       = cm_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    wait_d     = wait_q;
    data_d     = data_q;
    dims_d     = dims_q;
    err_code_d = err_code_q;
    error_d    = 1'b0;
    meta_req   = 1'b0;
    meta_id    = '0;
    rd_req     = 1'b0;
    rd_id      = '0;
    rd_addr    = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_op_idx = 2'd0;
    out_row    = 3'd0;
    out_col    = 3'd0;
    out_last   = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op_sel;
          id_d       = id_in;
          cm_d       = col_major;
          idx_d      = 2'd0;
          dims_d     = '0;
          err_code_d = ERR_NONE;
          state_d    = S_META_REQ;
        end
      end

      // First visit doubles as the operation check in the cycle after start.
      S_META_REQ: begin
        if (op_bad) begin
          err_code_d = ERR_OP;
          state_d    = S_ERR;
        end else if (int'(cur_id) >= SLOTS) begin
          err_code_d = ERR_ID_DIM;
          state_d    = S_ERR;
        end else begin
          meta_req = 1'b1;
          meta_id  = cur_id;
          wait_d   = '0;
          state_d  = S_META_WAIT;
        end
      end

      S_META_WAIT: begin
        if (meta_valid) begin
          dims_d[int'(idx_q)*6 +: 6] = {meta_m, meta_n};
          if (!dims_ok) begin
            err_code_d = ERR_ID_DIM;
            state_d    = S_ERR;
          end else if (last_op) begin
            state_d = S_CHECK;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_META_REQ;
          end
        end else if (timed_out) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      S_CHECK: begin
        if (((op_q == OP_ADD) && ((ma != mb) || (na != nb))) ||
            ((op_q == OP_MATMUL) && (na != mb))) begin
          err_code_d = ERR_DIM_MIS;
          state_d    = S_ERR;
        end else begin
          idx_d   = 2'd0;
          row_d   = 3'd0;
          col_d   = 3'd0;
          state_d = S_ELEM_REQ;
        end
      end

      S_ELEM_REQ: begin
        rd_req  = 1'b1;
        rd_id   = cur_id;
        rd_addr = cur_addr;
        wait_d  = '0;
        state_d = S_ELEM_WAIT;
      end

      S_ELEM_WAIT: begin
        if (rd_valid) begin
          data_d  = rd_data;
          state_d = S_ELEM_OUT;
        end else if (timed_out) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      S_ELEM_OUT: begin
        out_valid  = 1'b1;
        out_data   = data_q;
        out_op_idx = idx_q;
        out_row    = row_q;
        out_col    = col_q;
        out_last   = last_elem && last_op;
        if (out_ready) begin
          if (last_elem) begin
            if (last_op) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 2'd1;
              row_d   = 3'd0;
              col_d   = 3'd0;
              state_d = S_ELEM_REQ;
            end
          end else begin
            state_d = S_ELEM_REQ;
            if (cm_active) begin
              if (row_q == cur_m - 3'd1) begin
                row_d = 3'd0;
                col_d = col_q + 3'd1;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              if (col_q == cur_n - 3'd1) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
              end else begin
                col_d = col_q + 3'd1;
              end
            end
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      // error is registered so its pulse lands on the first IDLE cycle.
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// tb/tb_matrix_operand_fetch.sv - directed self-checking bench for matrix_operand_fetch
// Storage/metadata responder answers one cycle after each request; OPERAND_COLMAJOR_EN selects the column-major expectation.
module tb_matrix_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op_sel;
  logic [7:0]  id_in;
  logic        col_major;
  logic        meta_req;
  logic [3:0]  meta_id;
  logic        meta_valid;
  logic        meta_present;
  logic [2:0]  meta_m, meta_n;
  logic        rd_req;
  logic [3:0]  rd_id;
  logic [4:0]  rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_op_idx;
  logic [2:0]  out_row, out_col;
  logic        out_last;
  logic [11:0] dims_out;
  logic        busy, done, error;
  logic [2:0]  err_code;

  matrix_operand_fetch dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .id_in(id_in),
    .col_major(col_major), .meta_req(meta_req), .meta_id(meta_id),
    .meta_valid(meta_valid), .meta_present(meta_present), .meta_m(meta_m),
    .meta_n(meta_n), .rd_req(rd_req), .rd_id(rd_id), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op_idx(out_op_idx),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .dims_out(dims_out), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_meta = 0;
  int n_rd = 0;
  int last_rd_cyc = 0;
  bit rd_en = 1'b1;
  int rd_log[$];

  bit st_present[16];
  int st_m[16];
  int st_n[16];

  int t_op[$], t_row[$], t_col[$], t_data[$], t_last[$], t_cyc[$];
  bit got_done, got_err, stall_ok;
  int done_cyc, err_cyc, stall_rd0, stall_rd1;
  logic [7:0] hd;
  logic [2:0] hr, hc;

  function automatic logic [7:0] elem_val(input int id, input int addr);
    return 8'(id * 37 + addr * 5 + 3);
  endfunction

  // Metadata/storage responder and request monitor.
  initial begin : responder
    bit pm, pr;
    int pm_id, pr_id, pr_addr;
    pm = 0; pr = 0; pm_id = 0; pr_id = 0; pr_addr = 0;
    meta_valid = 0; meta_present = 0; meta_m = 0; meta_n = 0;
    rd_valid = 0; rd_data = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      meta_valid = 0;
      rd_valid = 0;
      if (rst) begin
        pm = 0; pr = 0;
      end else begin
        if (pm) begin
          meta_valid = 1;
          meta_present = st_present[pm_id];
          meta_m = 3'(st_m[pm_id]);
          meta_n = 3'(st_n[pm_id]);
          pm = 0;
        end
        if (pr && rd_en) begin
          rd_valid = 1;
          rd_data = elem_val(pr_id, pr_addr);
        end
        pr = 0;
        if (meta_req) begin
          pm = 1; pm_id = int'(meta_id); n_meta++;
        end
        if (rd_req) begin
          pr = 1; pr_id = int'(rd_id); pr_addr = int'(rd_addr);
          n_rd++; last_rd_cyc = cyc; rd_log.push_back(int'(rd_addr));
        end
      end
    end
  end

  task automatic do_start(input logic [2:0] op, input logic [7:0] ids, input logic cm);
    @(negedge clk);
    start = 1; op_sel = op; id_in = ids; col_major = cm;
    @(negedge clk);
    start = 0;
  endtask

  // Drives out_ready and records transfers until done/error or budget expiry.
  task automatic run_stream(input int stall_elem, input int stall_cyc, input int budget);
    int e, held;
    bit finished;
    e = 0; held = 0; finished = 0;
    t_op.delete(); t_row.delete(); t_col.delete();
    t_data.delete(); t_last.delete(); t_cyc.delete();
    got_done = 0; got_err = 0; stall_ok = 1; done_cyc = 0; err_cyc = 0;
    out_ready = 0;
    for (int i = 0; i < budget && !finished; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1; done_cyc = cyc; finished = 1;
      end else if (error) begin
        got_err = 1; err_cyc = cyc; finished = 1;
      end else if (out_valid) begin
        if (e == stall_elem && held < stall_cyc) begin
          if (held == 0) begin
            hd = out_data; hr = out_row; hc = out_col; stall_rd0 = n_rd;
          end else if (out_data !== hd || out_row !== hr || out_col !== hc) begin
            stall_ok = 0;
          end
          held++;
          out_ready = 0;
        end else begin
          if (e == stall_elem && held > 0) begin
            stall_rd1 = n_rd;
            if (out_data !== hd || out_row !== hr || out_col !== hc) stall_ok = 0;
          end
          out_ready = 1;
          t_op.push_back(int'(out_op_idx)); t_row.push_back(int'(out_row));
          t_col.push_back(int'(out_col)); t_data.push_back(int'(out_data));
          t_last.push_back(int'(out_last)); t_cyc.push_back(cyc);
          e++;
        end
      end else begin
        out_ready = 0;
      end
    end
    out_ready = 0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL run_timeout: no done/error within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; op_sel = 0; id_in = 0; col_major = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, out_valid, meta_req, rd_req, out_last} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, error, out_valid, meta_req, rd_req, out_last});
    end
    checks++;
    if (err_code !== 3'd0 || dims_out !== 12'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: err_code=%0d dims=%h data=%h want 0", err_code, dims_out, out_data);
    end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    int id, r, c;
    do_start(3'b001, {4'd2, 4'd1}, 1'b0);
    run_stream(-1, 0, 300);
    checks++;
    if (t_op.size() != 12) begin
      failures++;
      $display("FAIL add_count: got %0d transfers want 12", t_op.size());
    end else begin
      for (int e = 0; e < 12; e++) begin
        id = (e < 6) ? 1 : 2;
        r = (e % 6) / 3;
        c = e % 3;
        checks++;
        if (t_op[e] != e / 6 || t_row[e] != r || t_col[e] != c ||
            t_data[e] != int'(elem_val(id, r * 3 + c)) || t_last[e] != ((e == 11) ? 1 : 0)) begin
          failures++;
          $display("FAIL add_elem%0d: got op%0d r%0d c%0d d%0d l%0d want op%0d r%0d c%0d d%0d l%0d",
                   e, t_op[e], t_row[e], t_col[e], t_data[e], t_last[e],
                   e / 6, r, c, elem_val(id, r * 3 + c), (e == 11));
        end
      end
      checks++;
      if (t_cyc[11] - t_cyc[0] != 33) begin
        failures++;
        $display("FAIL add_throughput: got %0d cycles want 33", t_cyc[11] - t_cyc[0]);
      end
      checks++;
      if (!got_done || done_cyc - t_cyc[11] != 1) begin
        failures++;
        $display("FAIL add_done: got done=%0d delay=%0d want 1,1", got_done, done_cyc - t_cyc[11]);
      end
    end
    checks++;
    if (err_code !== 3'b000 || dims_out !== 12'b010_011_010_011) begin
      failures++;
      $display("FAIL add_status: err_code=%b dims=%b want 000 010011010011", err_code, dims_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL add_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_matmul_mismatch();
    int rd0, m0;
    rd0 = n_rd; m0 = n_meta;
    do_start(3'b011, {4'd4, 4'd3}, 1'b0);
    run_stream(-1, 0, 100);
    checks++;
    if (!got_err || err_code !== 3'b010) begin
      failures++;
      $display("FAIL mismatch_err: error=%0d err_code=%b want 1 010", got_err, err_code);
    end
    checks++;
    if (n_rd - rd0 != 0 || n_meta - m0 != 2) begin
      failures++;
      $display("FAIL mismatch_reqs: rd_req=%0d meta_req=%0d want 0 2", n_rd - rd0, n_meta - m0);
    end
  endtask

  task automatic test_bad_id();
    int m0;
    m0 = n_meta;
    do_start(3'b000, {4'd0, 4'd12}, 1'b0);
    run_stream(-1, 0, 50);
    checks++;
    if (!got_err || err_code !== 3'b001 || n_meta != m0) begin
      failures++;
      $display("FAIL bad_id: error=%0d err_code=%b meta_req=%0d want 1 001 0", got_err, err_code, n_meta - m0);
    end
  endtask

  task automatic test_unsupported();
    int m0;
    m0 = n_meta;
    do_start(3'b101, {4'd2, 4'd1}, 1'b0);
    run_stream(-1, 0, 50);
    checks++;
    if (!got_err || err_code !== 3'b011 || n_meta != m0) begin
      failures++;
      $display("FAIL unsupported_op: error=%0d err_code=%b meta_req=%0d want 1 011 0", got_err, err_code, n_meta - m0);
    end
  endtask

  task automatic test_stall();
    do_start(3'b010, {4'd0, 4'd5}, 1'b0);
    run_stream(3, 5, 300);
    checks++;
    if (!got_done || t_op.size() != 9) begin
      failures++;
      $display("FAIL stall_count: done=%0d transfers=%0d want 1 9", got_done, t_op.size());
    end
    checks++;
    if (hd !== elem_val(5, 3) || hr !== 3'd1 || hc !== 3'd0) begin
      failures++;
      $display("FAIL stall_values: got d%0d r%0d c%0d want d%0d r1 c0", hd, hr, hc, elem_val(5, 3));
    end
    checks++;
    if (!stall_ok) begin
      failures++;
      $display("FAIL stall_stable: held outputs changed, got unstable want stable");
    end
    checks++;
    if (stall_rd1 != stall_rd0) begin
      failures++;
      $display("FAIL stall_no_read: got %0d rd_req during stall want 0", stall_rd1 - stall_rd0);
    end
  endtask

  task automatic test_timeout();
    rd_en = 0;
    do_start(3'b001, {4'd2, 4'd1}, 1'b0);
    run_stream(-1, 0, 200);
    rd_en = 1;
    checks++;
    if (!got_err || err_code !== 3'b100) begin
      failures++;
      $display("FAIL timeout_err: error=%0d err_code=%b want 1 100", got_err, err_code);
    end
    checks++;
    if (err_cyc - last_rd_cyc != 66) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles want 66", err_cyc - last_rd_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, pulse;
    seen = 0; pulse = 0;
    do_start(3'b010, {4'd0, 4'd5}, 1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (!seen || {busy, done, error, out_valid, meta_req, rd_req} !== 6'b0 ||
        err_code !== 3'd0 || dims_out !== 12'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid: seen=%0d ctrl=%b err_code=%b dims=%h data=%h want 1 000000 000 0 0",
               seen, {busy, done, error, out_valid, meta_req, rd_req}, err_code, dims_out, out_data);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || error || busy) pulse = 1;
    end
    checks++;
    if (pulse) begin
      failures++;
      $display("FAIL reset_mid_quiet: got activity after abort want none");
    end
  endtask

  task automatic test_colmajor();
    int exp_addr[12];
    int exp_r, exp_c;
`ifdef OPERAND_COLMAJOR_EN
    exp_addr = '{0, 1, 2, 3, 4, 5, 0, 2, 4, 1, 3, 5};
    exp_r = 1; exp_c = 0;
`else
    exp_addr = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    exp_r = 0; exp_c = 1;
`endif
    rd_log.delete();
    do_start(3'b011, {4'd6, 4'd3}, 1'b1);
    run_stream(-1, 0, 300);
    checks++;
    if (!got_done || rd_log.size() != 12 || t_op.size() != 12) begin
      failures++;
      $display("FAIL colmajor_count: done=%0d reads=%0d transfers=%0d want 1 12 12", got_done, rd_log.size(), t_op.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rd_log[i] != exp_addr[i]) begin
          failures++;
          $display("FAIL colmajor_addr%0d: got %0d want %0d", i, rd_log[i], exp_addr[i]);
        end
      end
      checks++;
      if (t_row[7] != exp_r || t_col[7] != exp_c || t_data[7] != int'(elem_val(6, exp_addr[7]))) begin
        failures++;
        $display("FAIL colmajor_coord: got r%0d c%0d d%0d want r%0d c%0d d%0d",
                 t_row[7], t_col[7], t_data[7], exp_r, exp_c, elem_val(6, exp_addr[7]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      st_present[i] = 0; st_m[i] = 0; st_n[i] = 0;
    end
    st_present[1] = 1; st_m[1] = 2; st_n[1] = 3;
    st_present[2] = 1; st_m[2] = 2; st_n[2] = 3;
    st_present[3] = 1; st_m[3] = 2; st_n[3] = 3;
    st_present[4] = 1; st_m[4] = 2; st_n[4] = 2;
    st_present[5] = 1; st_m[5] = 3; st_n[5] = 3;
    st_present[6] = 1; st_m[6] = 3; st_n[6] = 2;

    test_reset();
    test_add();
    test_matmul_mismatch();
    test_bad_id();
    test_unsupported();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_colmajor();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
